// File: rtl/vec_pkg.sv
// vec_pkg: shared lane geometry, lane vector type and writeback FSM states.
package vec_pkg;
    localparam int LANES = 16;
    localparam int N = 16;
    localparam int CNT_W = $clog2(LANES);
    localparam int REG_ADDR_W = 4;
    typedef logic [LANES-1:0][N-1:0] lane_vec_t;
    typedef enum logic [1:0] {IDLE, STORE, LOAD, DRAIN} wb_state_t;
endpackage

// File: rtl/vector_mem_writeback_if.sv
// vector_mem_writeback_if: pipe-register inputs, lane-wide memory port and register-file write port.
interface vector_mem_writeback_if;
    import vec_pkg::*;
    lane_vec_t ALUResultW;
    lane_vec_t writeDataW;
    logic [REG_ADDR_W-1:0] WA3W;
    logic RegWriteW;
    logic MemtoRegW;
    logic MemWriteW;
    logic stall;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic mem_we;
    logic mem_re;
    logic [N-1:0] mem_rdata;
    logic rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    lane_vec_t rf_wd;
    modport slave (
        input ALUResultW, writeDataW, WA3W, RegWriteW, MemtoRegW, MemWriteW, mem_rdata,
        output stall, mem_addr, mem_wdata, mem_we, mem_re, rf_we, rf_wa, rf_wd
    );
    modport master (
        output ALUResultW, writeDataW, WA3W, RegWriteW, MemtoRegW, MemWriteW, mem_rdata,
        input stall, mem_addr, mem_wdata, mem_we, mem_re, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/vector_mem_writeback_lane_buffer.sv
// vector_lane_buffer: LANES x N register array with full-vector load, single-lane write and indexed read.
module vector_lane_buffer
    import vec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_en,
    input  lane_vec_t load_vec,
    input  logic wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [N-1:0] wr_data,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [N-1:0] rd_data,
    output lane_vec_t q
);
    lane_vec_t mem_q, mem_d;
    always_comb begin
        mem_d = mem_q;
        if (load_en) mem_d = load_vec;
        else if (wr_en) mem_d[wr_idx] = wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else mem_q <= mem_d;
    end
    assign rd_data = mem_q[rd_idx];
    assign q = mem_q;
endmodule

// File: rtl/vector_mem_writeback.sv
// vector_mem_writeback: Execute->Writeback consumer; scatters stores and gathers loads one lane
// per cycle, stalling the pipe while busy, and drives the vector register-file write port.
module vector_mem_writeback
    import vec_pkg::*;
(
    input logic clk,
    input logic reset,
    vector_mem_writeback_if.slave bus
);
    wb_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, ld_idx;
    logic [REG_ADDR_W-1:0] wa3_q, wa3_d, rf_wa_q, rf_wa_d;
    logic rf_we_q, rf_we_d;
    lane_vec_t rf_wd_q, rf_wd_d, ld_vec, unused_addr_q, unused_data_q;
    logic [N-1:0] addr_lane, data_lane, unused_ld_lane;
    logic cap, ld_wr, last;
    assign last = cnt_q == CNT_W'(LANES - 1);
    assign ld_idx = cnt_q - 1'b1;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        wa3_d = wa3_q;
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        cap = 1'b0;
        ld_wr = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.MemWriteW) begin
                    state_d = STORE;
                    cap = 1'b1;
                end else if (bus.MemtoRegW && bus.RegWriteW) begin
                    state_d = LOAD;
                    cap = 1'b1;
                    wa3_d = bus.WA3W;
                end else if (bus.RegWriteW && !bus.MemtoRegW) begin
                    rf_we_d = 1'b1;
                    rf_wa_d = bus.WA3W;
                    rf_wd_d = bus.ALUResultW;
                end
            end
            STORE: begin
                cnt_d = cnt_q + 1'b1;
                state_d = last ? IDLE : STORE;
            end
            LOAD: begin
                // read data lags the address by one cycle, so lane cnt-1 lands now
                cnt_d = cnt_q + 1'b1;
                ld_wr = cnt_q != '0;
                state_d = last ? DRAIN : LOAD;
            end
            DRAIN: begin
                state_d = IDLE;
                rf_we_d = 1'b1;
                rf_wa_d = wa3_q;
                rf_wd_d = ld_vec;
                rf_wd_d[LANES-1] = bus.mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            wa3_q <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wa3_q <= wa3_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end
    vector_lane_buffer u_addr (
        .clk(clk), .rst(reset), .load_en(cap), .load_vec(bus.ALUResultW),
        .wr_en(1'b0), .wr_idx('0), .wr_data('0),
        .rd_idx(cnt_q), .rd_data(addr_lane), .q(unused_addr_q)
    );
    vector_lane_buffer u_data (
        .clk(clk), .rst(reset), .load_en(cap), .load_vec(bus.writeDataW),
        .wr_en(1'b0), .wr_idx('0), .wr_data('0),
        .rd_idx(cnt_q), .rd_data(data_lane), .q(unused_data_q)
    );
    vector_lane_buffer u_ld (
        .clk(clk), .rst(reset), .load_en(1'b0), .load_vec('0),
        .wr_en(ld_wr), .wr_idx(ld_idx), .wr_data(bus.mem_rdata),
        .rd_idx(cnt_q), .rd_data(unused_ld_lane), .q(ld_vec)
    );
    assign bus.stall = state_q != IDLE;
    assign bus.mem_we = state_q == STORE;
    assign bus.mem_re = state_q == LOAD;
    assign bus.mem_addr = (state_q == STORE || state_q == LOAD) ? addr_lane : '0;
    assign bus.mem_wdata = (state_q == STORE) ? data_lane : '0;
    assign bus.rf_we = rf_we_q;
    assign bus.rf_wa = rf_wa_q;
    assign bus.rf_wd = rf_wd_q;
endmodule
